// File: rtl/sprite_compositor_if.sv
// Pixel-stream bundle for sprite_compositor: background + sprite layers in,
// composited colour out, with sideband and layer-enable status.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 2,
    parameter int SB_W       = 2
);
    logic                    in_valid;
    logic                    display;
    logic                    frame_start;
    logic [NUM_LAYERS-1:0]   layer_en_in;
    logic [11:0]             bg;
    logic [16*NUM_LAYERS-1:0] sprites;
    logic [SB_W-1:0]         sb_in;
    logic                    out_valid;
    logic [11:0]             y;
    logic [SB_W-1:0]         sb_out;
    logic [NUM_LAYERS-1:0]   layer_en_active;

    // Pixel source side (ROM readout / timing generator).
    modport master (
        output in_valid, display, frame_start, layer_en_in, bg, sprites, sb_in,
        input  out_valid, y, sb_out, layer_en_active
    );

    // Compositor side.
    modport slave (
        input  in_valid, display, frame_start, layer_en_in, bg, sprites, sb_in,
        output out_valid, y, sb_out, layer_en_active
    );
endinterface

// File: rtl/sprite_compositor.sv
// Composites NUM_LAYERS RGBA4444 sprite layers over an RGB444 background.
// Stage 0 registers the beat, stages 1..NUM_LAYERS each apply one layer
// bottom-up, and an output register follows, for a latency of NUM_LAYERS+1.
module sprite_compositor #(
    parameter int                    NUM_LAYERS = 2,
    parameter int                    BLEND_MODE = 1,
    parameter int                    SB_W       = 2,
    parameter logic [NUM_LAYERS-1:0] RESET_EN   = '1
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_compositor_if.slave bus
);

    // One in-flight beat. Every beat carries its own mask so a mask change
    // at frame_start never affects beats already in the pipe.
    typedef struct packed {
        logic                     valid;
        logic                     display;
        logic [NUM_LAYERS-1:0]    mask;
        logic [11:0]              acc;
        logic [16*NUM_LAYERS-1:0] spr;
        logic [SB_W-1:0]          sb;
    } beat_t;

    beat_t                 stage_q [NUM_LAYERS+1];
    beat_t                 stage_d [NUM_LAYERS+1];
    logic [NUM_LAYERS-1:0] layer_en_active_q, layer_en_active_d;
    logic [NUM_LAYERS-1:0] mask_sel;
    logic                  out_valid_q, out_valid_d;
    logic [11:0]           y_q, y_d;
    logic [SB_W-1:0]       sb_out_q, sb_out_d;

    // One 4-bit channel of the 16-level blend; ap is the expanded alpha 0..16.
    function automatic logic [3:0] blend_ch(input logic [3:0] s,
                                            input logic [3:0] acc,
                                            input logic [4:0] ap);
        logic [8:0] sum;
        sum = 9'(s) * 9'(ap) + 9'(acc) * 9'(5'd16 - ap);
        return 4'(sum >> 4);
    endfunction

    // Lay one RGBA4444 sprite pixel over the accumulated colour.
    function automatic logic [11:0] apply_layer(input logic [11:0] acc,
                                                input logic [15:0] spr,
                                                input logic        en);
        logic [3:0]  a;
        logic [4:0]  ap;
        logic [11:0] res;
        a   = en ? spr[3:0] : 4'd0;
        // Stretch 0..15 to 0..16 so alpha 15 reproduces the sprite exactly.
        ap  = {1'b0, a} + {4'd0, a[3]};
        res = acc;
        if (BLEND_MODE == 0) begin
            if (a != 4'd0) res = spr[15:4];
        end else begin
            for (int c = 0; c < 3; c++)
                res[4*c +: 4] = blend_ch(spr[4 + 4*c +: 4], acc[4*c +: 4], ap);
        end
        return res;
    endfunction

    // Next-state for mask latch, input stage, blend stages and output.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can
        // leave it unassigned and infer a latch.
        mask_sel          = (bus.frame_start & bus.in_valid) ? bus.layer_en_in
                                                             : layer_en_active_q;
        layer_en_active_d = mask_sel;

        stage_d[0].valid   = bus.in_valid;
        stage_d[0].display = bus.display;
        stage_d[0].mask    = mask_sel;
        stage_d[0].acc     = bus.bg;
        stage_d[0].spr     = bus.sprites;
        stage_d[0].sb      = bus.sb_in;

        // Stage j applies layer NUM_LAYERS-j, so layer 0 lands last (on top).
        for (int j = 1; j <= NUM_LAYERS; j++) begin
            stage_d[j]     = stage_q[j-1];
            stage_d[j].acc = apply_layer(stage_q[j-1].acc,
                                         stage_q[j-1].spr[16*(NUM_LAYERS-j) +: 16],
                                         stage_q[j-1].mask[NUM_LAYERS-j] &
                                         stage_q[j-1].display);
        end

        // Outputs hold their last value across bubbles.
        out_valid_d = stage_q[NUM_LAYERS].valid;
        y_d         = stage_q[NUM_LAYERS].valid ? stage_q[NUM_LAYERS].acc : y_q;
        sb_out_d    = stage_q[NUM_LAYERS].valid ? stage_q[NUM_LAYERS].sb  : sb_out_q;
    end

    // Pipeline, mask and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data fields are reset along with the valids; clearing
            // the valids alone would discard in-flight beats, the rest just
            // keeps reset state deterministic and is cheap at this depth.
            for (int i = 0; i <= NUM_LAYERS; i++) stage_q[i] <= '0;
            layer_en_active_q <= RESET_EN;
            out_valid_q       <= 1'b0;
            y_q               <= '0;
            sb_out_q          <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // previous stage's old value on the same edge.
            for (int i = 0; i <= NUM_LAYERS; i++) stage_q[i] <= stage_d[i];
            layer_en_active_q <= layer_en_active_d;
            out_valid_q       <= out_valid_d;
            y_q               <= y_d;
            sb_out_q          <= sb_out_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.y               = y_q;
    assign bus.sb_out          = sb_out_q;
    assign bus.layer_en_active = layer_en_active_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench: two compositors (alpha blend and colour key) fed the same
// stream; every beat's expected colour is written by hand per mode, and a
// monitor checks latency, bubbles, held outputs and sideband alignment.
module tb_sprite_compositor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int          due;
        logic [11:0] y1;
        logic [11:0] y0;
        logic [1:0]  sb;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [11:0] last_y1 = '0;
    logic [11:0] last_y0 = '0;
    logic [1:0]  last_sb = '0;

    sprite_compositor_if #(.NUM_LAYERS(2), .SB_W(2)) if1 ();
    sprite_compositor_if #(.NUM_LAYERS(2), .SB_W(2)) if0 ();

    sprite_compositor #(.NUM_LAYERS(2), .BLEND_MODE(1), .SB_W(2)) u_dut_blend (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    sprite_compositor #(.NUM_LAYERS(2), .BLEND_MODE(0), .SB_W(2)) u_dut_key (
        .clk(clk), .rst_n(rst_n), .bus(if0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic fs, input logic [1:0] en, input logic disp,
                         input logic [11:0] bg, input logic [31:0] spr, input logic [1:0] sb);
        if1.in_valid = v;  if1.frame_start = fs; if1.layer_en_in = en; if1.display = disp;
        if1.bg = bg;       if1.sprites = spr;    if1.sb_in = sb;
        if0.in_valid = v;  if0.frame_start = fs; if0.layer_en_in = en; if0.display = disp;
        if0.bg = bg;       if0.sprites = spr;    if0.sb_in = sb;
    endtask

    // One valid beat; e1/e0 are the expected colours for blend / key mode.
    task automatic beat(input logic fs, input logic [1:0] en, input logic disp,
                        input logic [11:0] bg, input logic [31:0] spr, input logic [1:0] sb,
                        input logic [11:0] e1, input logic [11:0] e0);
        @(negedge clk);
        drive(1'b1, fs, en, disp, bg, spr, sb);
        q.push_back('{due: cyc + 4, y1: e1, y0: e0, sb: sb});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 2'b11, 1'b1, 12'hEEE, 32'hFFFF_FFFF, 2'b00);
        end
    endtask

    // Output monitor: a beat must appear exactly on its due cycle; otherwise
    // out_valid is low and y/sb_out hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("blend_valid", {31'd0, if1.out_valid}, 32'd1);
                check("key_valid",   {31'd0, if0.out_valid}, 32'd1);
                check("blend_y",     {20'd0, if1.y}, {20'd0, e.y1});
                check("key_y",       {20'd0, if0.y}, {20'd0, e.y0});
                check("blend_sb",    {30'd0, if1.sb_out}, {30'd0, e.sb});
                last_y1 = e.y1; last_y0 = e.y0; last_sb = e.sb;
            end else begin
                check("bubble_valid", {31'd0, if1.out_valid}, 32'd0);
                check("bubble_key",   {31'd0, if0.out_valid}, 32'd0);
                check("hold_y",       {20'd0, if1.y}, {20'd0, last_y1});
                check("hold_sb",      {30'd0, if1.sb_out}, {30'd0, last_sb});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 2'b00, 1'b1, 12'h000, 32'h0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  {31'd0, if1.out_valid}, 32'd0);
        check("rst_y",      {20'd0, if1.y}, 32'd0);
        check("rst_sb",     {30'd0, if1.sb_out}, 32'd0);
        check("rst_mask",   {30'd0, if1.layer_en_active}, 32'h3);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Transparent layers: background passes through, latency 3.
        beat(1'b0, 2'b11, 1'b1, 12'h123, 32'h0000_0000, 2'b01, 12'h123, 12'h123);
        idle(4);
        // Opaque top layer wins over opaque lower layer.
        beat(1'b1, 2'b11, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b10, 12'hF00, 12'hF00);
        // Layer 0 disabled from this frame_start beat on.
        beat(1'b1, 2'b10, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b11, 12'h0F0, 12'h0F0);
        @(posedge clk); #1;
        check("mask_latched", {30'd0, if1.layer_en_active}, 32'h2);
        // Half alpha (a=8) on layer 0.
        beat(1'b1, 2'b11, 1'b1, 12'h000, 32'h0000_F008, 2'b00, 12'h800, 12'hF00);
        beat(1'b0, 2'b11, 1'b1, 12'h0F0, 32'h0000_F008, 2'b01, 12'h860, 12'hF00);
        // Alpha 1: key mode fully opaque, blend mode barely moves.
        beat(1'b0, 2'b11, 1'b1, 12'h456, 32'h0000_ABC1, 2'b10, 12'h456, 12'hABC);
        // Outside visible area: background only.
        beat(1'b0, 2'b11, 1'b0, 12'h789, 32'h0000_ABC1, 2'b11, 12'h789, 12'h789);
        // Half alpha on the bottom layer only.
        beat(1'b0, 2'b11, 1'b1, 12'h000, 32'h0F08_0000, 2'b00, 12'h080, 12'h0F0);
        idle(2);

        // Mid-frame enable change is ignored until the next frame_start.
        beat(1'b0, 2'b10, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b01, 12'hF00, 12'hF00);
        @(posedge clk); #1;
        check("mask_midframe", {30'd0, if1.layer_en_active}, 32'h3);
        beat(1'b1, 2'b10, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b10, 12'h0F0, 12'h0F0);
        beat(1'b0, 2'b11, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b11, 12'h0F0, 12'h0F0);
        @(posedge clk); #1;
        check("mask_new_frame", {30'd0, if0.layer_en_active}, 32'h2);

        // Back-to-back ramp, one beat per cycle.
        for (int i = 0; i < 20; i++)
            beat(1'b0, 2'b11, 1'b1, 12'(12'h100 + i * 12'h011), 32'h0000_0000, 2'(i),
                 12'(12'h100 + i * 12'h011), 12'(12'h100 + i * 12'h011));
        idle(5);

        // Reset with three beats in flight.
        beat(1'b1, 2'b01, 1'b1, 12'h00F, 32'h0F0F_F00F, 2'b01, 12'hF00, 12'hF00);
        beat(1'b0, 2'b01, 1'b1, 12'h0AA, 32'h0F0F_F00F, 2'b10, 12'hF00, 12'hF00);
        beat(1'b0, 2'b01, 1'b1, 12'h0BB, 32'h0F0F_F00F, 2'b11, 12'hF00, 12'hF00);
        @(posedge clk); #2;
        check("mask_before_rst", {30'd0, if1.layer_en_active}, 32'h1);
        mon_en = 1'b0;
        q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, if1.out_valid}, 32'd0);
        check("async_rst_y",     {20'd0, if1.y}, 32'd0);
        check("async_rst_ykey",  {20'd0, if0.y}, 32'd0);
        check("async_rst_mask",  {30'd0, if1.layer_en_active}, 32'h3);
        // frame_start during reset must not latch.
        @(negedge clk);
        drive(1'b1, 1'b1, 2'b10, 1'b1, 12'h000, 32'h0, 2'b00);
        @(posedge clk); #1;
        check("rst_beats_fs",    {30'd0, if1.layer_en_active}, 32'h3);
        check("rst_hold_valid",  {31'd0, if1.out_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'b11, 1'b1, 12'h000, 32'h0, 2'b00);
        rst_n   = 1'b1;
        last_y1 = '0; last_y0 = '0; last_sb = '0;
        mon_en  = 1'b1;
        idle(4);
        beat(1'b0, 2'b11, 1'b1, 12'h321, 32'h0000_0000, 2'b10, 12'h321, 12'h321);
        idle(6);

        check("drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor of the single-sprite background/sprite select.
- Composites NUM_LAYERS RGBA4444 sprite layers over a 12-bit RGB444 background pixel stream.
- Supports colour-key (opaque/transparent) or 16-level alpha-blend mode, with a fixed-latency pipeline.
- Sits between the sprite ROM readout/address logic and the VGA output register; sideband (hsync/vsync) is delayed to stay aligned with pixel data.

Parameters:
- NUM_LAYERS, 2, sprite layer count (1..8); layer 0 is topmost priority.
- BLEND_MODE, 1, 0 = colour key (alpha!=0 fully opaque), 1 = alpha blend.
- SB_W, 2, sideband width carried alongside pixels (e.g. {hsync,vsync}).
- RESET_EN, all ones, layer enable mask value after reset.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel beat valid (no backpressure)
- display  in  1  pixel inside visible area
- frame_start  in  1  first pixel of frame; qualified by in_valid
- layer_en_in  in  NUM_LAYERS  requested layer enable mask
- bg  in  12  background RGB444
- sprites  in  16*NUM_LAYERS  layer k at [16k+15:16k]; [15:4] = RGB444, [3:0] = alpha
- sb_in  in  SB_W  sideband in
- out_valid  out  1  output beat valid
- y  out  12  composited RGB444
- sb_out  out  SB_W  sideband, delayed to match y
- layer_en_active  out  NUM_LAYERS  mask currently in use

Behaviour:
- Reset, async on rst_n low: all pipeline valids 0, out_valid 0, y 0, sb_out 0, layer_en_active = RESET_EN. In-flight beats are discarded; the first out_valid after release comes from a beat accepted after release.
- Latency: the beat sampled at edge t (in_valid = 1) appears on y/sb_out/out_valid = 1 at edge t + NUM_LAYERS + 1.
- Stage 0 registers the inputs. Stages 1..NUM_LAYERS each blend one layer, bottom-up: stage j applies layer NUM_LAYERS-j over the accumulated colour. The final stage drives the output registers.
- Fully pipelined: one beat per cycle sustained. in_valid = 0 inserts a bubble that propagates with its valid bit. y and sb_out hold their last value while out_valid = 0.
- Mask latch: when frame_start & in_valid, layer_en_active <= layer_en_in. That beat and all later beats use the new mask. layer_en_in changes mid-frame have no effect until the next frame_start. Each beat carries its own mask copy through the pipe.
- Per-layer effective alpha: a = 0 if layer disabled or display = 0; otherwise alpha.
- BLEND_MODE 0: a != 0 -> acc = rgb; a = 0 -> acc unchanged.
- BLEND_MODE 1: a' = a + (a >> 3), range 0..16. Per 4-bit channel: acc = (s*a' + acc*(16-a')) >> 4, with 9-bit intermediate and truncation. a = 15 gives exactly s; a = 0 gives exactly acc.
- display = 0: y = bg regardless of sprites (all layers forced transparent).
- All layers transparent: y = bg exactly.
- Simultaneous frame_start and reset: reset wins, mask = RESET_EN.

Test Plan:
- NUM_LAYERS = 2, mode 1: bg = 0x123, both alphas 0, in_valid pulse at t -> out_valid = 1 at t+3, y = 0x123.
- Top layer sprite = 0xF00F, layer1 = 0x0F0F, bg = 0x00F -> y = 0xF00. Disable layer0 via mask at frame_start -> y = 0x0F0.
- Mode 1: layer0 = 0xF008 (a = 8, a' = 9), layer1 alpha 0, bg = 0x000 -> y = 0x800. bg = 0x0F0 -> y = 0x860.
- Mode 0: layer0 alpha = 1, rgb = 0xABC -> y = 0xABC. Same beat with display = 0 -> y = bg.
- Change layer_en_in mid-frame -> layer_en_active and output unchanged. Next frame_start beat -> new mask applied on exactly that pixel. Continuous in_valid stream with a ramping bg pattern -> output ramp contiguous, 1 beat/cycle, sb_out aligned.
- Assert rst_n low with 3 beats in flight -> out_valid = 0 and y = 0 immediately. No stale beats after release. layer_en_active = RESET_EN.
